// File: rtl/pattern_scan_ctrl_if.sv
// Word-side handshake between a word producer and pattern_scan_ctrl.
// The producer side uses the master modport and the controller uses the slave modport.
interface pattern_scan_ctrl_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
);
    logic [WIDTH-1:0] word;
    logic             word_valid;
    logic             clear_between;
    logic             word_ready;
    logic             busy;
    logic [CNT_W-1:0] match_count;
    logic             result_valid;

    modport master (
        output word, word_valid, clear_between,
        input  word_ready, busy, match_count, result_valid
    );

    modport slave (
        input  word, word_valid, clear_between,
        output word_ready, busy, match_count, result_valid
    );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Sequencing controller for the serial "101" detector.
// Each accepted word is shifted into the detector MSB-first, one bit per clock.
// The detector's match pulses are counted per word, and the count is reported with a
// one-cycle result strobe.
module pattern_scan_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    pattern_scan_ctrl_if.slave    bus,
    output logic                  det_bit,
    output logic                  det_nreset,
    input  logic                  det_match
);
    localparam int unsigned IdxW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StClr, StShift, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] sreg_q;
    logic [IdxW-1:0]  idx_q;

    // Detector drive: serial bit only while shifting, reset during CLR or controller reset
    assign det_bit    = (state_q == StShift) & sreg_q[WIDTH-1];
    assign det_nreset = ~reset & (state_q != StClr);

    // Controller FSM with registered handshake/status outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q              <= StIdle;
            sreg_q               <= '0;
            idx_q                <= '0;
            bus.word_ready       <= 1'b1;
            bus.busy             <= 1'b0;
            bus.result_valid     <= 1'b0;
            bus.match_count      <= '0;
        end else begin
            bus.result_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.word_valid) begin
                        sreg_q          <= bus.word;
                        idx_q           <= '0;
                        bus.match_count <= '0;
                        bus.word_ready  <= 1'b0;
                        bus.busy        <= 1'b1;
                        state_q         <= bus.clear_between ? StClr : StShift;
                    end
                end
                StClr: begin
                    state_q <= StShift;
                end
                StShift: begin
                    // det_match is Mealy, so it belongs to the bit being retired at this edge
                    if (det_match && (bus.match_count != {CNT_W{1'b1}})) begin
                        bus.match_count <= bus.match_count + 1'b1;
                    end
                    sreg_q <= {sreg_q[WIDTH-2:0], 1'b0};
                    idx_q  <= idx_q + 1'b1;
                    if (idx_q == LastIdx) begin
                        state_q          <= StDone;
                        bus.result_valid <= 1'b1;
                    end
                end
                StDone: begin
                    state_q        <= StIdle;
                    bus.word_ready <= 1'b1;
                    bus.busy       <= 1'b0;
                end
                default: begin
                    state_q        <= StIdle;
                    bus.word_ready <= 1'b1;
                    bus.busy       <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl.
// Stimulus pushes the expected count and result cycle for each word into a scoreboard queue.
// A monitor process pops an entry from the queue and compares it whenever result_valid is seen.
module tb_pattern_scan_ctrl;
    localparam int unsigned WIDTH = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    pattern_scan_ctrl_if #(.WIDTH(WIDTH), .CNT_W(4)) bus ();
    pattern_scan_ctrl_if #(.WIDTH(WIDTH), .CNT_W(2)) bus2 ();

    logic det_bit, det_nreset, det_match;
    logic det_bit2, det_nreset2;
    logic tb_match  = 1'b0;
    logic use_model = 1'b0;
    logic model_match;
    logic [1:0] ds;

    pattern_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus.slave),
        .det_bit    (det_bit),
        .det_nreset (det_nreset),
        .det_match  (det_match)
    );

    pattern_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(2)) dut2 (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus2.slave),
        .det_bit    (det_bit2),
        .det_nreset (det_nreset2),
        .det_match  (1'b1)
    );

    // Behavioural overlapping Mealy "101" detector standing in for the real instance
    always_ff @(posedge clock or negedge det_nreset) begin
        if (!det_nreset) ds <= 2'd0;
        else begin
            case (ds)
                2'd0:    ds <= det_bit ? 2'd1 : 2'd0;
                2'd1:    ds <= det_bit ? 2'd1 : 2'd2;
                default: ds <= det_bit ? 2'd1 : 2'd0;
            endcase
        end
    end
    assign model_match = (ds == 2'd2) & det_bit;
    assign det_match   = use_model ? model_match : tb_match;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nrst_low = 0;

    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) if (det_nreset === 1'b0) nrst_low <= nrst_low + 1;

    typedef struct {
        int cnt;
        int cyc;
    } exp_t;
    exp_t sb[$];
    int   sb2[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Reference: overlapping "101" occurrences in a word scanned MSB-first from a fresh detector
    function automatic int ref_count(input logic [7:0] w);
        int n = 0;
        for (int i = 7; i >= 2; i--) if (w[i] && !w[i-1] && w[i-2]) n++;
        return n;
    endfunction

    // Monitor for the main instance
    always @(negedge clock) begin
        exp_t e;
        if (bus.result_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got result_valid=1 count=%0d at cycle %0d, required none",
                         bus.match_count, cyc);
            end else begin
                e = sb.pop_front();
                check("result_count", 32'(bus.match_count), e.cnt);
                check("result_cycle", cyc, e.cyc);
            end
        end
    end

    // Monitor for the saturation instance
    always @(negedge clock) begin
        int e2;
        if (bus2.result_valid === 1'b1) begin
            if (sb2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result2: got result_valid=1 at cycle %0d, required none", cyc);
            end else begin
                e2 = sb2.pop_front();
                check("sat_count", 32'(bus2.match_count), e2);
            end
        end
    end

    // Offer a word, wait (bounded) for acceptance, return the acceptance cycle.
    // Returns at #1 after the acceptance edge, i.e. at the start of cycle 1.
    task automatic send(input logic [7:0] w, input logic clr, input logic m0, input logic keep,
                        input logic push, input int exp_cnt, output int acc);
        int t = 0;
        @(negedge clock);
        bus.word          = w;
        bus.clear_between = clr;
        bus.word_valid    = 1'b1;
        tb_match          = m0;
        while (bus.word_ready !== 1'b1 && t < 40) begin
            @(negedge clock);
            t++;
        end
        if (t >= 40) begin
            check("accept_timeout", 32'(t), 0);
            bus.word_valid = 1'b0;
            acc = -1;
        end else begin
            @(posedge clock);
            #1;
            acc = cyc;
            if (!keep) bus.word_valid = 1'b0;
            if (push) sb.push_back('{exp_cnt, acc + (clr ? WIDTH + 1 : WIDTH)});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, n0, t;
        bus.word = '0; bus.word_valid = 1'b0; bus.clear_between = 1'b0;
        bus2.word = '0; bus2.word_valid = 1'b0; bus2.clear_between = 1'b0;

        // Reset values
        repeat (3) begin
            @(negedge clock);
            check("rst_word_ready", bus.word_ready, 1);
            check("rst_busy", bus.busy, 0);
            check("rst_det_nreset", det_nreset, 0);
            check("rst_match_count", 32'(bus.match_count), 0);
        end
        check("rst_result_valid", bus.result_valid, 0);
        check("rst_det_bit", det_bit, 0);
        reset = 1'b0;

        // Abort mid-word: reset in the 4th SHIFT cycle (cycle 5 with clear)
        send(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 0, acc);
        repeat (4) @(posedge clock);
        #1;
        check("abort_pre_count", 32'(bus.match_count), 3);
        #1;
        reset = 1'b1;
        #1;
        check("abort_word_ready", bus.word_ready, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_match_count", 32'(bus.match_count), 0);
        check("abort_det_nreset", det_nreset, 0);
        check("abort_det_bit", det_bit, 0);
        tb_match = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // Serialisation and latency with clear
        send(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 0, acc);
        n0 = nrst_low;
        for (int k = 1; k <= 10; k++) begin
            logic [7:0] w;
            logic eb;
            w  = 8'hA5;
            eb = (k >= 2 && k <= 9) ? w[9-k] : 1'b0;
            @(negedge clock);
            check($sformatf("ser_det_bit_c%0d", k), det_bit, eb);
            if (k == 1) check("ser_det_nreset_clr", det_nreset, 0);
        end
        #1;
        check("ser_nreset_low_cycles", nrst_low - n0, 1);

        // Counting: matches on SHIFT cycles 2, 5, 7 (cycles 3, 6, 8); also high in IDLE/CLR/DONE
        send(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 3, acc);
        for (int k = 1; k <= 11; k++) begin
            tb_match = (k == 1 || k == 3 || k == 6 || k == 8 || k >= 10);
            @(posedge clock);
            #1;
        end
        tb_match = 1'b0;
        check("count_hold_idle", 32'(bus.match_count), 3);

        // No-clear, back-to-back with word_valid held
        send(8'h0F, 1'b0, 1'b0, 1'b1, 1'b1, 0, acc);
        n0 = nrst_low;
        send(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 0, acc2);
        check("b2b_accept_spacing", acc2 - acc, WIDTH + 2);
        repeat (10) @(negedge clock);
        #1;
        check("noclr_nreset_low_cycles", nrst_low - n0, 0);

        // Integration with the behavioural detector
        use_model = 1'b1;
        send(8'b1010_0101, 1'b1, 1'b0, 1'b0, 1'b1, ref_count(8'b1010_0101), acc);
        repeat (12) @(negedge clock);
        use_model = 1'b0;

        // Saturation on the CNT_W=2 instance: 8 matches must stop at 3
        @(negedge clock);
        bus2.word = 8'h3C; bus2.clear_between = 1'b0; bus2.word_valid = 1'b1;
        t = 0;
        while (bus2.word_ready !== 1'b1 && t < 40) begin
            @(negedge clock);
            t++;
        end
        check("sat_accept_wait", 32'(t), 0);
        @(posedge clock);
        #1;
        bus2.word_valid = 1'b0;
        sb2.push_back(3);

        // Drain scoreboards (bounded)
        t = 0;
        while ((sb.size() != 0 || sb2.size() != 0) && t < 50) begin
            @(negedge clock);
            t++;
        end
        @(negedge clock);
        check("sb_drained", 32'(sb.size()), 0);
        check("sb2_drained", 32'(sb2.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Sequencing controller for the serial bit-pattern detector (the "101" recogniser). It accepts parallel words over a valid/ready handshake and shifts each word MSB-first into the detector, one bit per clock. It optionally resets the detector between words, counts the detector's match pulses per word, and reports the count with a one-cycle result strobe. It sits between a word-oriented producer and the detector instance.

## Interface
- WIDTH, 8: bits per word; legal range 2..32.
- CNT_W, 4: match counter width; must satisfy 2^CNT_W > WIDTH/2.

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- word  in  WIDTH  parallel data word to scan
- word_valid  in  1  producer has a word on `word`
- clear_between  in  1  sampled with the word: 1 = reset detector before scanning this word
- word_ready  out  1  controller can accept a word (IDLE only)
- det_bit  out  1  serial bit to detector `inp`
- det_nreset  out  1  active-low reset to detector `nreset`
- det_match  in  1  detector `outp` (Mealy: valid in the same cycle as det_bit)
- busy  out  1  high in CLR, SHIFT, DONE
- match_count  out  CNT_W  matches counted for the last or current word
- result_valid  out  1  one-cycle strobe; match_count is final

## Operation
- States: IDLE, CLR, SHIFT, DONE. Encoding is free; unreachable encodings go to IDLE on the next edge.
- **IDLE**
  - word_ready = 1.
  - On word_valid & word_ready at an edge:
    - Load word into the shift register.
    - Latch clear_between.
    - Clear match_count to 0.
    - Clear bit index to 0.
    - Go to CLR if clear_between = 1, else go to SHIFT.
- **CLR**
  - Exactly one cycle.
  - det_nreset = 0, det_bit = 0.
  - Go to SHIFT.
- **SHIFT**
  - Exactly WIDTH cycles.
  - det_bit = shift register MSB.
  - At each edge:
    - If det_match = 1, increment match_count, saturating at 2^CNT_W−1.
    - Shift left by one.
    - Increment bit index.
  - After the edge that consumes bit index WIDTH−1, go to DONE.
- **DONE**
  - Exactly one cycle.
  - result_valid = 1.
  - Go to IDLE.
- det_bit = 0 outside SHIFT.
- det_nreset = ~reset & ~(state == CLR). This is combinational, so the detector is held in reset whenever the controller is.
- det_match is ignored outside SHIFT.
- match_count holds its value from DONE through IDLE until the next word acceptance.
- With clear_between = 0, detector state carries across word boundaries. A pattern straddling two words is counted in the later word.
- word and clear_between are don't-care except at the acceptance edge.

## Timing
- Reset values:
  - state = IDLE
  - word_ready = 1
  - busy = 0
  - result_valid = 0
  - match_count = 0
  - det_bit = 0
  - det_nreset = 0 while reset is high
- Reset asserted mid-word:
  - Controller returns to IDLE immediately (asynchronously).
  - The word is abandoned and no result_valid is produced.
- Latency from the acceptance edge to the result_valid cycle:
  - clear_between = 1: result_valid is high in cycle WIDTH+2 after acceptance (CLR + WIDTH SHIFT + DONE).
  - clear_between = 0: WIDTH+1.
- Throughput: one word per WIDTH+3 cycles (clear) or WIDTH+2 cycles (no clear). word_ready is low from the cycle after acceptance through DONE.
- A word_valid held high across DONE is accepted at the first IDLE edge. No bubble beyond the IDLE cycle itself.
- det_match is sampled at the same edge that retires the current det_bit. There is no extra pipeline stage.

## Test plan
- **Reset values and abort.** Hold reset for 3 cycles.
  - During reset: word_ready=1, busy=0, det_nreset=0, match_count=0.
  - Then accept word 8'hA5, assert reset in the 4th SHIFT cycle.
  - Required: immediate IDLE, result_valid never pulses, match_count=0.
- **Serialisation and latency with clear.** Accept 8'hA5 with clear_between=1, det_match tied 0.
  - det_nreset=0 for exactly 1 cycle.
  - det_bit sequence = 1,0,1,0,0,1,0,1 over 8 consecutive cycles.
  - result_valid in cycle 10 after acceptance, match_count=0.
- **Counting.** Accept 8'hFF, bench drives det_match=1 on SHIFT cycles 2, 5 and 7.
  - Required: match_count=3 on result_valid.
  - det_match=1 in IDLE/CLR/DONE must not change the count.
- **No-clear path and back-to-back.** Hold word_valid=1 with 8'h0F then 8'hF0, clear_between=0.
  - Required: det_nreset never low after reset release.
  - Second word accepted exactly 1 cycle after the first DONE.
  - Spacing between result_valid pulses = 10 cycles.
- **Saturation.** Use WIDTH=8, CNT_W=2 with det_match=1 on all 8 SHIFT cycles.
  - Required: match_count=3, no wrap to 0.
- **Integration with the real detector.** Stream 8'b1010_0101 with clear_between=1 into the real "101" detector.
  - Required: match_count equals a bench reference model of the detector fed the same bit sequence.
  - result_valid fires exactly once.
